// File: rtl/rf_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader and its neighbours
// (register file, CPU top): register-file geometry and the dump FSM states.
package rf_dump_reader_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } dump_state_e;

  // A snooped write makes the dump incoherent when it lands on a non-zero
  // register that has already been sampled (first..idx). idx itself counts:
  // during its FETCH cycle the pre-write value is the one captured.
  function automatic logic snoop_hit(
    input logic                  wr_en,
    input logic [REG_ADDR_W-1:0] wr_addr,
    input logic [REG_ADDR_W-1:0] first,
    input logic [REG_ADDR_W-1:0] idx
  );
    return wr_en && (wr_addr != {REG_ADDR_W{1'b0}}) &&
           (wr_addr >= first) && (wr_addr <= idx);
  endfunction

endpackage

// File: rtl/rf_dump_reader.sv
// Register-file dump reader: walks the register-file read port from
// FIRST_REG to LAST_REG and streams each value over valid/ready, flagging
// the dump dirty when an already-sampled register is overwritten mid-dump.
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [REG_DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_DATA_W-1:0] out_data,
  output logic [REG_ADDR_W-1:0] out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  dirty
);

  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

  dump_state_e             state_q,     state_d;
  logic [REG_ADDR_W-1:0]   idx_q,       idx_d;
  logic                    out_valid_q, out_valid_d;
  logic [REG_DATA_W-1:0]   out_data_q,  out_data_d;
  logic [REG_ADDR_W-1:0]   out_idx_q,   out_idx_d;
  logic                    out_last_q,  out_last_d;
  logic                    busy_q,      busy_d;
  logic                    done_q,      done_d;
  logic                    dirty_q,     dirty_d;

  // Next-state logic: dump sequencing, handshake, abort and dirty snooping.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dirty_d     = dirty_q;

    // Sticky coherency flag; only a new accepted start clears it.
    if (busy_q && snoop_hit(wr_en, wr_addr, FIRST_IDX, idx_q)) begin
      dirty_d = 1'b1;
    end else begin
      dirty_d = dirty_q;
    end

    case (state_q)
      ST_IDLE: begin
        // start beats a simultaneous abort; abort alone does nothing here.
        if (start) begin
          state_d = ST_FETCH;
          idx_d   = FIRST_IDX;
          dirty_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH: begin
        if (abort) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          dirty_d     = dirty_q;
        end else begin
          // rd_addr has equalled idx for this whole cycle, so rd_data is valid.
          out_data_d  = rd_data;
          out_idx_d   = idx_q;
          out_last_d  = (idx_q == LAST_IDX);
          out_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (abort) begin
          // Abort wins over a same-cycle handshake; no done pulse.
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          dirty_d     = dirty_q;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // LAST_REG ends the walk, so idx never needs to wrap.
            idx_d   = idx_q + 5'd1;
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_SEND;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= FIRST_IDX;
      out_valid_q <= 1'b0;
      out_data_q  <= {REG_DATA_W{1'b0}};
      out_idx_q   <= {REG_ADDR_W{1'b0}};
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dirty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dirty_q     <= dirty_d;
    end
  end

  // The read address is the registered index itself.
  assign rd_addr   = idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dirty     = dirty_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed self-checking bench for rf_dump_reader, paired with a small
// behavioural register file (r0 reads 0, writes on the rising edge).
module tb_rf_dump_reader;
  import rf_dump_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic        start2 = 1'b0, abort2 = 1'b0, out_ready2 = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic [4:0]  rd_addr, rd_addr2, out_idx, out_idx2;
  logic [31:0] rd_data, rd_data2, out_data, out_data2;
  logic        out_valid, out_last, busy, done, dirty;
  logic        out_valid2, out_last2, busy2, done2, dirty2;

  logic [31:0] regs [NUM_REGS];

  int checks = 0;
  int failures = 0;

  // collector results / configuration
  int          nwords, done_cnt, last_hs_cyc, done_cyc;
  logic        dirty_at_done;
  logic [31:0] got_data [32];
  logic [4:0]  got_idx  [32];
  logic        got_last [32];
  int          stall_idx, stall_len, start_word, abort_idx;
  int          wtrig [2];
  logic [4:0]  waddr [2];
  logic [31:0] wdata [2];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
  end
  assign rd_data  = (rd_addr  == 5'd0) ? 32'd0 : regs[rd_addr];
  assign rd_data2 = (rd_addr2 == 5'd0) ? 32'd0 : regs[rd_addr2];

  rf_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done),
    .dirty(dirty)
  );

  rf_dump_reader #(.FIRST_REG(7), .LAST_REG(7)) dut7 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .wr_en(wr_en), .wr_addr(wr_addr),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_idx(out_idx2), .out_last(out_last2), .busy(busy2), .done(done2),
    .dirty(dirty2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int s_idx, input int s_len, input int s_word, input int a_idx,
                     input int t0, input logic [4:0] a0, input logic [31:0] d0,
                     input int t1, input logic [4:0] a1, input logic [31:0] d1);
    stall_idx = s_idx; stall_len = s_len; start_word = s_word; abort_idx = a_idx;
    wtrig[0] = t0; waddr[0] = a0; wdata[0] = d0;
    wtrig[1] = t1; waddr[1] = a1; wdata[1] = d1;
  endtask

  // Runs from a negedge with the DUT busy; drives ready/writes/start/abort
  // and records every accepted word until done (or abort / budget).
  task automatic collect(input int budget);
    int  stall_ctr = 0;
    bit  fin = 0;
    bit  start_fired = 0;
    bit  wf0 = 0, wf1 = 0;
    nwords = 0; done_cnt = 0; last_hs_cyc = -1; done_cyc = -2;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      start = 1'b0; abort = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
      if (done) begin
        done_cnt++; done_cyc = cyc; dirty_at_done = dirty; fin = 1;
      end else begin
        if (busy && !out_valid) begin
          if (!wf0 && int'(rd_addr) == wtrig[0]) begin
            wr_en = 1'b1; wr_addr = waddr[0]; wr_data = wdata[0]; wf0 = 1;
          end else if (!wf1 && int'(rd_addr) == wtrig[1]) begin
            wr_en = 1'b1; wr_addr = waddr[1]; wr_data = wdata[1]; wf1 = 1;
          end
        end
        if (stall_ctr > 0 && stall_ctr < stall_len) begin
          out_ready = 1'b0;
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, 32'h1000_0003);
          chk("stall_idx", out_idx, 3);
          stall_ctr++;
        end else if (out_valid) begin
          if (int'(out_idx) == abort_idx) begin
            abort = 1'b1; fin = 1;
          end else if (int'(out_idx) == stall_idx && stall_ctr == 0) begin
            out_ready = 1'b0; stall_ctr = 1;
          end else begin
            if (nwords < 32) begin
              got_data[nwords] = out_data; got_idx[nwords] = out_idx; got_last[nwords] = out_last;
            end
            nwords++;
            if (out_last) last_hs_cyc = cyc;
          end
        end
        if (nwords == start_word && !start_fired && busy) begin
          start = 1'b1; start_fired = 1;
        end
      end
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
    if (!fin) chk("collect_timeout", 0, 1);
  endtask

  task automatic pulse_start(input logic with_abort);
    start = 1'b1; abort = with_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    int quiet_done;
    int ok;
    #3 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    // reset state
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_rd_addr7", rd_addr2, 7);
    rst = 1'b1;

    // preload r1..r31 through the write port while idle
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h1000_0000 + 32'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("idle_dirty_after_preload", dirty, 0);

    // dump 1: full walk, stall 5 cycles at idx 3, start while busy ignored
    pulse_start(1'b0);
    chk("lat_busy", busy, 1);
    chk("lat_valid_fetch", out_valid, 0);
    chk("lat_rd_addr", rd_addr, 0);
    @(negedge clk);
    chk("lat_valid_send", out_valid, 1);
    chk("lat_first_idx", out_idx, 0);
    cfg(3, 5, 4, -1, -1, 5'd0, 32'd0, -1, 5'd0, 32'd0);
    collect(300);
    chk("d1_words", nwords, 32);
    ok = 1;
    for (int i = 0; i < 32; i++) begin
      if (got_idx[i] !== 5'(i)) ok = 0;
      if (got_data[i] !== ((i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i))) ok = 0;
      if (got_last[i] !== (i == 31)) ok = 0;
    end
    chk("d1_stream_contents", ok, 1);
    chk("d1_data3", got_data[3], 32'h1000_0003);
    chk("d1_last31", got_last[31], 1);
    chk("d1_done_count", done_cnt, 1);
    chk("d1_done_timing", done_cyc, last_hs_cyc + 1);
    chk("d1_dirty", dirty_at_done, 0);
    chk("d1_done_pulse_end", done, 0);
    chk("d1_busy_end", busy, 0);

    // dump 2: r20 written at idx 5 (ahead, dumped new), r0 written at idx 6
    pulse_start(1'b0);
    cfg(-1, 0, -1, -1, 5, 5'd20, 32'hCAFE_F00D, 6, 5'd0, 32'hFFFF_FFFF);
    collect(300);
    chk("d2_words", nwords, 32);
    chk("d2_r20_new", got_data[20], 32'hCAFE_F00D);
    chk("d2_r0_zero", got_data[0], 0);
    chk("d2_r21", got_data[21], 32'h1000_0015);
    chk("d2_dirty", dirty_at_done, 0);

    // dump 3: r2 overwritten at idx 5 -> dirty, old value already dumped
    pulse_start(1'b0);
    cfg(-1, 0, -1, -1, 5, 5'd2, 32'hDEAD_BEEF, -1, 5'd0, 32'd0);
    collect(300);
    chk("d3_words", nwords, 32);
    chk("d3_r2_old", got_data[2], 32'h1000_0002);
    chk("d3_r20", got_data[20], 32'hCAFE_F00D);
    chk("d3_dirty", dirty_at_done, 1);
    @(negedge clk);
    chk("d3_dirty_sticky", dirty, 1);

    // abort in IDLE has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_dirty", dirty, 1);

    // dump 4: start clears dirty, r3 written in its own FETCH, abort at idx 10
    pulse_start(1'b0);
    chk("d4_dirty_cleared", dirty, 0);
    cfg(-1, 0, -1, 10, 3, 5'd3, 32'h3333_3333, -1, 5'd0, 32'd0);
    collect(300);
    chk("d4_words", nwords, 10);
    chk("d4_r3_prewrite", got_data[3], 32'h1000_0003);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dirty_kept", dirty, 1);
    quiet_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) quiet_done++;
    end
    chk("abort_no_done", quiet_done, 0);

    // dump 5: start and abort together in IDLE -> start wins, restart at 0
    pulse_start(1'b1);
    chk("d5_busy", busy, 1);
    chk("d5_dirty_cleared", dirty, 0);
    chk("d5_rd_addr_first", rd_addr, 0);
    cfg(-1, 0, -1, -1, -1, 5'd0, 32'd0, -1, 5'd0, 32'd0);
    collect(300);
    chk("d5_words", nwords, 32);
    chk("d5_first_idx", got_idx[0], 0);
    chk("d5_r2", got_data[2], 32'hDEAD_BEEF);
    chk("d5_r3", got_data[3], 32'h3333_3333);
    chk("d5_dirty", dirty_at_done, 0);

    // single-register dump (FIRST_REG == LAST_REG == 7)
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("s7_busy", busy2, 1);
    chk("s7_fetch_valid", out_valid2, 0);
    chk("s7_rd_addr", rd_addr2, 7);
    @(negedge clk);
    chk("s7_valid", out_valid2, 1);
    chk("s7_idx", out_idx2, 7);
    chk("s7_data", out_data2, 32'h1000_0007);
    chk("s7_last", out_last2, 1);
    @(negedge clk);
    chk("s7_done", done2, 1);
    chk("s7_valid_end", out_valid2, 0);
    chk("s7_busy_end", busy2, 0);
    chk("s7_dirty", dirty2, 0);
    @(negedge clk);
    chk("s7_done_pulse", done2, 0);

    // reset asserted mid-SEND, between clock edges
    pulse_start(1'b0);
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      if (out_valid && out_idx == 5'd5) begin
        ok = 1; out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("rst_mid_reached_idx5", ok, 1);
    chk("rst_mid_pre_data", out_data, 32'h1000_0005);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_idx", out_idx, 0);
    chk("rst_mid_last", out_last, 0);
    chk("rst_mid_rd_addr", rd_addr, 0);
    chk("rst_mid_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
